// File: rtl/corr_accum_window.sv
// Windowed, saturating accumulator for correlator products with a one-deep AXI-Stream output register.
// Optional macro CORR_ACCUM_THRESH_EN adds thresh input and m_axis_tuser (|sum| >= thresh) output.
//
// state | meaning
// IDLE  | waiting for the first sample of a window
// RUN   | window open, accumulating until cnt reaches len
module corr_accum_window #(
  parameter int IN_WIDTH  = 18,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 s_axis_tvalid,
  input  logic [47:0]          s_axis_tdata,
  input  logic [CNT_WIDTH-1:0] win_len,
`ifdef CORR_ACCUM_THRESH_EN
  input  logic [ACC_WIDTH-1:0] thresh,
  output logic [0:0]           m_axis_tuser,
`endif
  output logic                 m_axis_tvalid,
  output logic [ACC_WIDTH-1:0] m_axis_tdata,
  input  logic                 m_axis_tready,
  output logic                 overrun
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [CNT_WIDTH-1:0]         len;
  logic                         done_q;

  logic signed [IN_WIDTH-1:0]   x_in;
  logic signed [ACC_WIDTH-1:0]  x_ext;
  logic signed [ACC_WIDTH:0]    sum_wide;
  logic signed [ACC_WIDTH-1:0]  acc_sat;
  logic [CNT_WIDTH-1:0]         len_start;
  logic [CNT_WIDTH-1:0]         cnt_next;
  logic                         unused_tdata;

  assign unused_tdata = ^s_axis_tdata[47:IN_WIDTH];
  assign x_in         = s_axis_tdata[IN_WIDTH-1:0];
  assign x_ext        = ACC_WIDTH'(x_in);
  assign sum_wide     = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(x_ext);
  assign len_start    = (win_len == '0) ? CNT_WIDTH'(1) : win_len;
  assign cnt_next     = cnt + 1'b1;

  // Top two bits of the widened sum disagree only on overflow
  always_comb begin
    acc_sat = sum_wide[ACC_WIDTH-1:0];
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
      acc_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

`ifdef CORR_ACCUM_THRESH_EN
  logic [ACC_WIDTH-1:0] thresh_q;
  logic [ACC_WIDTH-1:0] abs_acc;

  always_comb begin
    abs_acc = acc;
    if (acc == ACC_MIN)   abs_acc = ACC_MAX;
    else if (acc[ACC_WIDTH-1]) abs_acc = -acc;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      thresh_q     <= '0;
      m_axis_tuser <= '0;
    end else begin
      if (state == IDLE && s_axis_tvalid) thresh_q <= thresh;
      if (done_q && (!m_axis_tvalid || m_axis_tready)) m_axis_tuser <= (abs_acc >= thresh_q);
    end
  end
`endif

  // acc holds the finished sum during the cycle done_q is high; the output stage reads it then
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      len           <= '0;
      done_q        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      overrun       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            len <= len_start;
            acc <= x_ext;
            cnt <= CNT_WIDTH'(1);
            if (len_start == CNT_WIDTH'(1)) done_q <= 1'b1;
            else                            state  <= RUN;
          end
        end
        RUN: begin
          if (s_axis_tvalid) begin
            acc <= acc_sat;
            cnt <= cnt_next;
            if (cnt_next == len) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (done_q) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= acc;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_corr_accum_window.sv
// Bench for corr_accum_window: directed scenarios plus random traffic against a sample-queue level model.
module tb_corr_accum_window;
  localparam int IW = 18;
  localparam int AW = 20;
  localparam int CW = 12;
  localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (AW-1));

  logic          clk = 1'b0;
  logic          sync_reset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [47:0]   s_axis_tdata = '0;
  logic [CW-1:0] win_len = '0;
  logic          m_axis_tvalid;
  logic [AW-1:0] m_axis_tdata;
  logic          m_axis_tready = 1'b0;
  logic          overrun;
`ifdef CORR_ACCUM_THRESH_EN
  logic [AW-1:0] thresh = '0;
  logic [0:0]    m_axis_tuser;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state: samples of the open window, completed sum awaiting output, output register
  longint win_q[$];
  longint m_len, m_th, pend_sum, pend_th;
  logic   pend = 1'b0;
  logic   e_valid = 1'b0, e_over = 1'b0, e_user = 1'b0;
  longint e_data = 0;

  always #5 clk = ~clk;

  corr_accum_window #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .win_len(win_len),
`ifdef CORR_ACCUM_THRESH_EN
    .thresh(thresh), .m_axis_tuser(m_axis_tuser),
`endif
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tready(m_axis_tready), .overrun(overrun)
  );

  function automatic longint window_sum(input longint q[$]);
    longint s = 0;
    foreach (q[i]) begin
      s = s + q[i];
      if (s > AMAX) s = AMAX;
      if (s < AMIN) s = AMIN;
    end
    return s;
  endfunction

  function automatic logic over_thresh(input longint s, input longint th);
    longint a = (s < 0) ? -s : s;
    if (a > AMAX) a = AMAX;
    return a >= th;
  endfunction

  // one clock: drive inputs, advance the model across the edge, settle 1 time unit after it
  task automatic step(input logic rst, input logic v, input int x, input int wl, input logic rdy);
    longint th = 0;
    sync_reset    = rst;
    s_axis_tvalid = v;
    s_axis_tdata  = {30'($urandom), 18'(x)};
    win_len       = CW'(wl);
    m_axis_tready = rdy;
`ifdef CORR_ACCUM_THRESH_EN
    th = longint'(thresh);
`endif
    @(posedge clk);
    if (rst) begin
      win_q.delete();
      pend = 0; e_valid = 0; e_over = 0; e_user = 0; e_data = 0;
    end else begin
      if (pend) begin
        if (!e_valid || rdy) begin
          e_valid = 1; e_data = pend_sum; e_user = over_thresh(pend_sum, pend_th);
        end else e_over = 1;
      end else if (rdy) e_valid = 0;
      pend = 0;
      if (v) begin
        if (win_q.size() == 0) begin
          m_len = (wl == 0) ? 1 : wl;
          m_th  = th;
        end
        win_q.push_back(longint'(x));
        if (win_q.size() == m_len) begin
          pend = 1; pend_sum = window_sum(win_q); pend_th = m_th;
          win_q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_vec++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got v=%b d=%0d ovr=%b, want v=0 d=0 ovr=0", m_axis_tvalid, m_axis_tdata, overrun);
    end
  endtask

  task automatic test_basic();
    step(1, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) step(0, 1, i, 4, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL basic_early: got v=%b, want v=0", m_axis_tvalid);
    end
    step(0, 0, 0, 4, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(10)) begin
      n_err++; $display("FAIL basic_sum: got v=%b d=%0d, want v=1 d=10", m_axis_tvalid, $signed(m_axis_tdata));
    end
    step(0, 0, 0, 4, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL basic_single_beat: got v=%b, want v=0", m_axis_tvalid);
    end
  endtask

  task automatic test_gaps();
    step(1, 0, 0, 3, 1);
    step(0, 1, -5, 3, 1);
    step(0, 0, 99, 3, 1);
    step(0, 0, 99, 3, 1);
    step(0, 1, 2, 3, 1);
    step(0, 1, -1, 3, 1);
    step(0, 0, 0, 3, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(-4)) begin
      n_err++; $display("FAIL gaps_sum: got v=%b d=%0d, want v=1 d=-4", m_axis_tvalid, $signed(m_axis_tdata));
    end
  endtask

  task automatic test_len_zero();
    step(1, 0, 0, 0, 1);
    step(0, 1, 7, 0, 1);
    step(0, 1, 8, 0, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(7)) begin
      n_err++; $display("FAIL len0_first: got v=%b d=%0d, want v=1 d=7", m_axis_tvalid, $signed(m_axis_tdata));
    end
    step(0, 0, 0, 0, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(8)) begin
      n_err++; $display("FAIL len0_second: got v=%b d=%0d, want v=1 d=8", m_axis_tvalid, $signed(m_axis_tdata));
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 0, 8, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 131071, 8, 1);
    step(0, 0, 0, 8, 1);
    n_vec++;
    if (m_axis_tdata !== AW'(524287)) begin
      n_err++; $display("FAIL sat_max: got d=%0d, want d=524287", $signed(m_axis_tdata));
    end
    for (int i = 0; i < 8; i++) step(0, 1, -131072, 8, 1);
    step(0, 0, 0, 8, 1);
    n_vec++;
    if (m_axis_tdata !== AW'(-524288)) begin
      n_err++; $display("FAIL sat_min: got d=%0d, want d=-524288", $signed(m_axis_tdata));
    end
  endtask

  task automatic test_overrun();
    step(1, 0, 0, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 0, 0, 2, 0);
    step(0, 1, 3, 2, 0);
    step(0, 1, 3, 2, 0);
    step(0, 0, 0, 2, 0);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(2) || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_hold: got v=%b d=%0d ovr=%b, want v=1 d=2 ovr=1", m_axis_tvalid, $signed(m_axis_tdata), overrun);
    end
    step(0, 0, 0, 2, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b0 || overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_drain: got v=%b ovr=%b, want v=0 ovr=1", m_axis_tvalid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 3, 2, 0);
    step(0, 1, 3, 2, 0);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(2)) begin
      n_err++; $display("FAIL b2b_first: got v=%b d=%0d, want v=1 d=2", m_axis_tvalid, $signed(m_axis_tdata));
    end
    step(0, 0, 0, 2, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(6) || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got v=%b d=%0d ovr=%b, want v=1 d=6 ovr=0", m_axis_tvalid, $signed(m_axis_tdata), overrun);
    end
    step(0, 0, 0, 2, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain: got v=%b, want v=0", m_axis_tvalid);
    end
  endtask

  task automatic test_reset_mid_window();
    step(1, 0, 0, 1, 0);
    step(0, 1, 9, 1, 0);
    step(0, 1, 5, 4, 0);
    step(0, 1, 5, 4, 0);
    step(1, 0, 0, 4, 0);
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_drop: got v=%b, want v=0", m_axis_tvalid);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 1, 4, 1);
    step(0, 0, 0, 4, 1);
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== AW'(4) || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_sum: got v=%b d=%0d ovr=%b, want v=1 d=4 ovr=0", m_axis_tvalid, $signed(m_axis_tdata), overrun);
    end
  endtask

`ifdef CORR_ACCUM_THRESH_EN
  task automatic test_thresh();
    for (int k = 4; k <= 5; k++) begin
      thresh = AW'(k);
      step(1, 0, 0, 4, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 4, 1);
      thresh = '1;
      step(0, 0, 0, 4, 1);
      n_vec++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== ((k == 4) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL thresh_%0d: got v=%b user=%b, want v=1 user=%b", k, m_axis_tvalid, m_axis_tuser, k == 4);
      end
    end
  endtask
`endif

  task automatic test_random();
    int wl = 3;
    int x;
    step(1, 0, 0, wl, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) wl = $urandom_range(0, 6);
      case ($urandom_range(0, 3))
        0: x = 131071;
        1: x = -131072;
        default: x = int'($urandom_range(0, 262143)) - 131072;
      endcase
`ifdef CORR_ACCUM_THRESH_EN
      if ($urandom_range(0, 9) == 0) thresh = AW'($urandom_range(0, 600000));
`endif
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 7, x, wl, $urandom_range(0, 3) != 0);
      n_vec++;
      if (m_axis_tvalid !== e_valid || overrun !== e_over || (e_valid && m_axis_tdata !== AW'(e_data))) begin
        n_err++;
        $display("FAIL random_cyc%0d: got v=%b d=%0d ovr=%b, want v=%b d=%0d ovr=%b", i, m_axis_tvalid,
                 $signed(m_axis_tdata), overrun, e_valid, e_data, e_over);
      end
`ifdef CORR_ACCUM_THRESH_EN
      if (e_valid) begin
        n_vec++;
        if (m_axis_tuser !== e_user) begin
          n_err++; $display("FAIL random_user_cyc%0d: got %b, want %b", i, m_axis_tuser, e_user);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_len_zero();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid_window();
`ifdef CORR_ACCUM_THRESH_EN
    test_thresh();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
